vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA timing from the 100 MHz board clock for the flappy-bird display path.
- Sits between the CPU/game renderer and the VGA pins: it issues pixel coordinates to the renderer, takes back 12-bit RGB, and drives the registered VGA_HS_O, VGA_VS_O, VGA_R, VGA_G and VGA_B outputs.
- Also gives the renderer a vblank-aligned frame-buffer swap handshake.

Parameters:
- PIX_DIV, 4: board clocks per pixel tick (100 MHz / 4 = 25 MHz); legal range 1..16.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- SYNC_POL, 0: asserted level of both sync outputs (0 = active-low).

Ports:
- FPGA_GlobalClock  in  1  board clock; the only clock.
- RST  in  1  reset; synchronous, active-high.
- pix_rgb_i  in  12  renderer colour {R[11:8], G[7:4], B[3:0]} for the current pix_x/pix_y.
- swap_req_i  in  1  level: renderer requests a frame-buffer swap.
- pix_x  out  10  horizontal coordinate presented to the renderer.
- pix_y  out  10  vertical coordinate presented to the renderer.
- pix_req  out  1  high when pix_x/pix_y lie in the active area.
- pix_tick  out  1  one-clock strobe marking each pixel advance.
- frame_start  out  1  one-clock pulse when the counters reach (0,0).
- vblank  out  1  high while the line counter v >= V_ACTIVE.
- swap_ack_o  out  1  one-clock pulse; the swap is granted.
- VGA_HS_O  out  1  horizontal sync.
- VGA_VS_O  out  1  vertical sync.
- VGA_R  out  4  red.
- VGA_G  out  4  green.
- VGA_B  out  4  blue.

Behaviour:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 800; V_TOTAL = 525. Counters are unsigned; h uses 10 bits, v uses 10 bits.
- Divider:
  - div counts 0..PIX_DIV-1 and wraps.
  - pix_tick = (div == PIX_DIV-1), decoded combinationally from a register.
  - With PIX_DIV = 1, pix_tick is high every clock.
- Counters (advance only on pix_tick):
  - h increments each tick and wraps to 0 from H_TOTAL-1.
  - On the h wrap, v increments and wraps to 0 from V_TOTAL-1.
- Stage 0 (registered on pix_tick):
  - pix_x = h, pix_y = v, pix_req = (h < H_ACTIVE && v < V_ACTIVE).
  - Outside the active area, pix_x/pix_y still show the raw counters.
- Renderer contract: pix_rgb_i must be stable by the next pix_tick; it is sampled only on pix_tick.
- Stage 1 (registered on pix_tick):
  - Sync and colour outputs describe the coordinate held in stage 0.
  - Output latency is exactly one pixel tick after pix_x/pix_y change.
  - RGB = pix_req ? pix_rgb_i : 0; colour is forced to zero in blanking.
  - VGA_HS_O = SYNC_POL while H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - VGA_VS_O = SYNC_POL while 490 <= y < 492.
  - Both syncs are ~SYNC_POL otherwise.
- frame_start: pulses on the clock where stage 0 loads (0,0).
- vblank: combinational from stage-0 pix_y >= V_ACTIVE.
- Swap handshake:
  - A pending flag sets on any clock where swap_req_i = 1 and no ack is being issued.
  - swap_ack_o pulses for one clock on the pix_tick where stage 0 loads (0, V_ACTIVE), but only if the flag is set or swap_req_i is high in that same clock.
  - The flag clears on the ack.
  - A request that first rises on the ack clock is granted by that ack.
  - The renderer must drop swap_req_i within one frame; a request still high after the ack re-arms for the next vblank.
  - At most one ack per frame.
- Reset (any clock, including mid-line or mid-frame) forces on the next edge:
  - div, h, v, pix_x, pix_y = 0.
  - pix_req, frame_start, swap_ack_o, pending flag = 0.
  - VGA_HS_O = VGA_VS_O = ~SYNC_POL (1 at default).
  - VGA_R/G/B = 0.
  - With default parameters, the first pix_tick occurs PIX_DIV clocks after RST falls.
- Frame period: H_TOTAL * V_TOTAL * PIX_DIV = 1,680,000 clocks.

Test Plan:
- Release reset, free-run 2 frames -> frame_start pulses are exactly 1,680,000 clocks apart; VGA_HS_O low for 384 consecutive clocks per line with falling edges 3200 clocks apart; VGA_VS_O low for 2 lines (6400 clocks) per frame.
- Drive pix_rgb_i = {pix_x[3:0], pix_y[3:0], 4'hA} -> at output (x=5, y=7) RGB = 5/7/A one pixel tick after pix_x=5, pix_y=7; RGB = 0 at x=640..799 and y=480..524.
- Pulse swap_req_i for 1 clock at y=100 -> exactly one swap_ack_o, on the tick where stage 0 loads (0,480); none in the following frame.
- Raise swap_req_i in the same clock the (0,480) tick occurs -> ack in that clock; holding the request for 2 frames -> one ack per frame.
- Assert RST for 3 clocks at (h=700, v=491) -> syncs = 1, RGB = 0, counters = 0; first pix_tick after release produces pix_x = 0, pix_y = 0, frame_start = 1.
- Parameter run PIX_DIV = 1 -> pix_tick constant 1; frame period = 420,000 clocks.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing generator: pixel divider, h/v raster counters, a coordinate
// stage for the renderer, a registered sync/colour stage, and a vblank swap handshake.
module vga_timing_gen #(
  parameter int PIX_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        FPGA_GlobalClock,
  input  logic        RST,
  input  logic [11:0] pix_rgb_i,
  input  logic        swap_req_i,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_req,
  output logic        pix_tick,
  output logic        frame_start,
  output logic        vblank,
  output logic        swap_ack_o,
  output logic        VGA_HS_O,
  output logic        VGA_VS_O,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [3:0] div;
  logic [9:0] h;
  logic [9:0] v;
  logic       swap_pend;
  logic       swap_grant;
  logic       h_wrap;

  assign pix_tick = (div == DIV_LAST);
  assign vblank   = (pix_y >= V_ACT);
  assign h_wrap   = (h == H_LAST);

  // Grant lands on the tick that moves stage 0 onto the first vblank line.
  assign swap_grant = pix_tick && (h == 10'd0) && (v == V_ACT) && (swap_pend || swap_req_i);

  always_ff @(posedge FPGA_GlobalClock) begin
    if (RST) begin
      div <= '0;
      h   <= '0;
      v   <= '0;
    end else begin
      div <= pix_tick ? 4'd0 : div + 4'd1;
      if (pix_tick) begin
        h <= h_wrap ? 10'd0 : h + 10'd1;
        if (h_wrap) begin
          v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
        end
      end
    end
  end

  // Stage 0: coordinates handed to the renderer.
  always_ff @(posedge FPGA_GlobalClock) begin
    if (RST) begin
      pix_x       <= '0;
      pix_y       <= '0;
      pix_req     <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_tick) begin
        pix_x       <= h;
        pix_y       <= v;
        pix_req     <= (h < H_ACT) && (v < V_ACT);
        frame_start <= (h == 10'd0) && (v == 10'd0);
      end
    end
  end

  // Stage 1: pins describe the coordinate stage 0 held one tick earlier.
  always_ff @(posedge FPGA_GlobalClock) begin
    if (RST) begin
      VGA_HS_O <= ~SYNC_POL;
      VGA_VS_O <= ~SYNC_POL;
      VGA_R    <= '0;
      VGA_G    <= '0;
      VGA_B    <= '0;
    end else if (pix_tick) begin
      VGA_HS_O <= (pix_x >= HS_START && pix_x < HS_END) ? SYNC_POL : ~SYNC_POL;
      VGA_VS_O <= (pix_y >= VS_START && pix_y < VS_END) ? SYNC_POL : ~SYNC_POL;
      {VGA_R, VGA_G, VGA_B} <= pix_req ? pix_rgb_i : 12'h000;
    end
  end

  always_ff @(posedge FPGA_GlobalClock) begin
    if (RST) begin
      swap_pend  <= 1'b0;
      swap_ack_o <= 1'b0;
    end else begin
      swap_ack_o <= swap_grant;
      if (swap_grant) begin
        swap_pend <= 1'b0;
      end else if (swap_req_i) begin
        swap_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a shrunken raster (15x11 pixels) so whole frames fit in a
// short run; a second instance checks the PIX_DIV=1 corner.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  // Raster: H 8+2+3+2 = 15, V 6+2+1+2 = 11; hsync x=10..12, vsync y=8.
  localparam int PD          = 2;
  localparam int HA          = 8;
  localparam int VA          = 6;
  localparam int FRAME_CLKS  = 330;  // 15*11*2
  localparam int LINE_CLKS   = 30;   // 15*2
  localparam int HS_LOW_CLKS = 6;    // 3 pixels * 2
  localparam int VS_LOW_CLKS = 30;   // 1 line
  localparam int FRAME1_CLKS = 165;  // 15*11*1

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        swap_req = 1'b0;
  logic [11:0] rgb_in;
  logic [9:0]  pix_x, pix_y;
  logic        pix_req, pix_tick, frame_start, vblank, swap_ack_o, hs, vs;
  logic [3:0]  vr, vg, vb;

  logic [9:0]  d1_x, d1_y;
  logic        d1_req, d1_tick, d1_fs, d1_vblank, d1_ack, d1_hs, d1_vs;
  logic [3:0]  d1_r, d1_g, d1_b;

  always #5 clk = ~clk;

  assign rgb_in = {pix_x[3:0], pix_y[3:0], 4'hA};

  vga_timing_gen #(
    .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(VA), .V_FP(2), .V_SYNC(1), .V_BP(2), .SYNC_POL(1'b0)
  ) u_dut (
    .FPGA_GlobalClock(clk), .RST(rst), .pix_rgb_i(rgb_in), .swap_req_i(swap_req),
    .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req), .pix_tick(pix_tick),
    .frame_start(frame_start), .vblank(vblank), .swap_ack_o(swap_ack_o),
    .VGA_HS_O(hs), .VGA_VS_O(vs), .VGA_R(vr), .VGA_G(vg), .VGA_B(vb)
  );

  vga_timing_gen #(
    .PIX_DIV(1), .H_ACTIVE(HA), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(VA), .V_FP(2), .V_SYNC(1), .V_BP(2), .SYNC_POL(1'b0)
  ) u_dut1 (
    .FPGA_GlobalClock(clk), .RST(rst), .pix_rgb_i(12'h123), .swap_req_i(1'b0),
    .pix_x(d1_x), .pix_y(d1_y), .pix_req(d1_req), .pix_tick(d1_tick),
    .frame_start(d1_fs), .vblank(d1_vblank), .swap_ack_o(d1_ack),
    .VGA_HS_O(d1_hs), .VGA_VS_O(d1_vs), .VGA_R(d1_r), .VGA_G(d1_g), .VGA_B(d1_b)
  );

  typedef struct {
    int x;
    int y;
    int rgb;
    int hs;
    int vs;
  } pix_exp_t;

  pix_exp_t pix_q[$];
  int       fs_q[$];
  int       ack_q[$];
  int       checks = 0;
  int       failures = 0;
  int       cnt = 0;
  int       fr = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void add_pix(input int x, input int y, input int rgb, input int h, input int v);
    pix_exp_t e;
    e.x = x; e.y = y; e.rgb = rgb; e.hs = h; e.vs = v;
    pix_q.push_back(e);
  endfunction

  // Hand-computed stage-1 outputs for chosen frame-1 coordinates, in raster order.
  function automatic void push_frame_pix();
    pix_q.delete();
    add_pix(0,  0,  'h00A, 1, 1);
    add_pix(10, 2,  'h000, 0, 1);
    add_pix(12, 2,  'h000, 0, 1);
    add_pix(13, 2,  'h000, 1, 1);
    add_pix(5,  3,  'h53A, 1, 1);
    add_pix(7,  5,  'h75A, 1, 1);
    add_pix(8,  5,  'h000, 1, 1);
    add_pix(3,  6,  'h000, 1, 1);
    add_pix(3,  8,  'h000, 1, 0);
    add_pix(11, 8,  'h000, 0, 0);
    add_pix(3,  9,  'h000, 1, 1);
    add_pix(14, 10, 'h000, 1, 1);
  endfunction

  // Clocks since the last reset release.
  always @(posedge clk) begin
    if (rst) cnt = 0;
    else     cnt = cnt + 1;
  end

  logic     prev_tick, hs_d, vs_d;
  int       cap_x, cap_y, hs_fall_t, vs_fall_t;
  bit       cap_valid, hs_low_ok, hs_per_ok, vs_low_ok, vs_per_ok;
  pix_exp_t pe;
  int       ev;

  always @(negedge clk) begin
    if (rst) begin
      prev_tick = 1'b0; cap_valid = 0; fr = 0;
      hs_low_ok = 0; hs_per_ok = 0; vs_low_ok = 0; vs_per_ok = 0;
      hs_d = 1'b1; vs_d = 1'b1;
    end else begin
      if (frame_start) begin
        fr++;
        chk("frame_start_expected", int'(fs_q.size() > 0), 1);
        if (fs_q.size() > 0) begin
          ev = fs_q.pop_front();
          chk("frame_start_clk", cnt, ev);
          chk("frame_start_x", int'(pix_x), 0);
          chk("frame_start_y", int'(pix_y), 0);
        end
      end
      if (swap_ack_o) begin
        chk("swap_ack_expected", int'(ack_q.size() > 0), 1);
        if (ack_q.size() > 0) begin
          ev = ack_q.pop_front();
          chk("swap_ack_frame", fr, ev);
          chk("swap_ack_x", int'(pix_x), 0);
          chk("swap_ack_y", int'(pix_y), VA);
        end
      end
      if (prev_tick) begin
        if (cap_valid && pix_q.size() > 0 && pix_q[0].x == cap_x && pix_q[0].y == cap_y) begin
          pe = pix_q.pop_front();
          chk($sformatf("rgb_%0d_%0d", pe.x, pe.y), int'({vr, vg, vb}), pe.rgb);
          chk($sformatf("hs_%0d_%0d", pe.x, pe.y), int'(hs), pe.hs);
          chk($sformatf("vs_%0d_%0d", pe.x, pe.y), int'(vs), pe.vs);
        end
        cap_x = int'(pix_x); cap_y = int'(pix_y); cap_valid = 1;
      end
      prev_tick = pix_tick;
      if (hs_d && !hs) begin
        if (hs_per_ok) chk("hs_fall_period", cnt - hs_fall_t, LINE_CLKS);
        hs_fall_t = cnt; hs_per_ok = 1; hs_low_ok = 1;
      end
      if (!hs_d && hs && hs_low_ok) chk("hs_low_width", cnt - hs_fall_t, HS_LOW_CLKS);
      hs_d = hs;
      if (vs_d && !vs) begin
        if (vs_per_ok) chk("vs_fall_period", cnt - vs_fall_t, FRAME_CLKS);
        vs_fall_t = cnt; vs_per_ok = 1; vs_low_ok = 1;
      end
      if (!vs_d && vs && vs_low_ok) chk("vs_low_width", cnt - vs_fall_t, VS_LOW_CLKS);
      vs_d = vs;
    end
  end

  int d1_first = -1;
  int d1_gap = -1;
  int d1_low = 0;
  int d1_seen = 0;
  bit d1_done = 0;

  always @(negedge clk) begin
    if (!rst && !d1_done) begin
      d1_seen++;
      if (!d1_tick) d1_low++;
      if (d1_fs) begin
        if (d1_first < 0) d1_first = cnt;
        else begin
          d1_gap = cnt - d1_first;
          d1_done = 1;
        end
      end
    end
  end

  task automatic wait_xy(input int x, input int y);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(int'(pix_x) == x && int'(pix_y) == y) && n < 2000);
    chk("wait_x", int'(pix_x), x);
    chk("wait_y", int'(pix_y), y);
  endtask

  task automatic wait_frame(input int f);
    int n = 0;
    while (fr < f && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_frame", fr, f);
  endtask

  task automatic wait_ack();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!swap_ack_o && n < 2000);
    chk("wait_ack", int'(swap_ack_o), 1);
  endtask

  initial begin
    push_frame_pix();
    fs_q  = '{2, 2 + FRAME_CLKS, 2 + 2*FRAME_CLKS, 2 + 3*FRAME_CLKS, 2 + 4*FRAME_CLKS, 2 + 5*FRAME_CLKS};
    ack_q = '{1, 3, 4};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hs", int'(hs), 1);
    chk("rst_vs", int'(vs), 1);
    chk("rst_tick", int'(pix_tick), 0);
    rst = 1'b0;

    // Frame 1: single-clock request mid-frame is held until vblank.
    wait_xy(0, 2);
    chk("req_active", int'(pix_req), 1);
    chk("vblank_active", int'(vblank), 0);
    swap_req = 1'b1;
    @(posedge clk); #1;
    swap_req = 1'b0;

    // Frame 3: request first rises on the granting tick clock, then held.
    wait_frame(3);
    wait_xy(14, 5);
    @(posedge clk); #1;
    chk("tick_before_grant", int'(pix_tick), 1);
    swap_req = 1'b1;
    @(posedge clk); #1;
    chk("ack_on_raise_clock", int'(swap_ack_o), 1);
    wait_frame(4);
    wait_ack();
    swap_req = 1'b0;

    // Frame 6: arm a request after the grant point, then reset mid-sync.
    wait_frame(6);
    wait_xy(0, 7);
    swap_req = 1'b1;
    @(posedge clk); #1;
    swap_req = 1'b0;
    wait_xy(11, 8);
    chk("req_blank", int'(pix_req), 0);
    chk("vblank_y8", int'(vblank), 1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_rst_x", int'(pix_x), 0);
    chk("mid_rst_y", int'(pix_y), 0);
    chk("mid_rst_req", int'(pix_req), 0);
    chk("mid_rst_fs", int'(frame_start), 0);
    chk("mid_rst_ack", int'(swap_ack_o), 0);
    chk("mid_rst_vblank", int'(vblank), 0);
    chk("mid_rst_hs", int'(hs), 1);
    chk("mid_rst_vs", int'(vs), 1);
    chk("mid_rst_rgb", int'({vr, vg, vb}), 0);
    chk("mid_rst_tick", int'(pix_tick), 0);
    chk("leftover_fs_q", fs_q.size(), 0);
    chk("leftover_ack_q", ack_q.size(), 0);
    chk("leftover_pix_q", pix_q.size(), 0);
    push_frame_pix();
    fs_q = '{2, 2 + FRAME_CLKS};
    rst = 1'b0;

    wait_frame(2);
    repeat (20) @(posedge clk);
    #1;
    chk("end_fs_q", fs_q.size(), 0);
    chk("end_ack_q", ack_q.size(), 0);
    chk("end_pix_q", pix_q.size(), 0);
    chk("div1_first_fs_clk", d1_first, 1);
    chk("div1_frame_period", d1_gap, FRAME1_CLKS);
    chk("div1_tick_low_count", d1_low, 0);
    chk("div1_samples_seen", int'(d1_seen > 100), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
